// File: rtl/dem_lru_select_if.sv
// rtl/dem_lru_select_if.sv - request/response handshake bundle for the DAC element selector
interface dem_lru_select_if #(
  parameter int N_EL = 18
);
  logic            in_valid;
  logic [4:0]      in_count;
  logic            in_ready;
  logic            out_valid;
  logic [N_EL-1:0] out_sel;

  modport master (
    output in_valid, in_count,
    input  in_ready, out_valid, out_sel
  );

  modport slave (
    input  in_valid, in_count,
    output in_ready, out_valid, out_sel
  );
endinterface

// File: rtl/dem_lru_select.sv
// rtl/dem_lru_select.sv - least-recently-used element selector for the 18-element unit DAC
// Picks one highest-priority element per cycle using the external max stage, then ages the rest.
module dem_lru_select #(
  parameter int N_EL = 18,
  parameter int PW   = 7
) (
  input  logic          clk,
  input  logic          rst,
  dem_lru_select_if.slave bus,
  output logic [PW-1:0] pri0,
  output logic [PW-1:0] pri1,
  output logic [PW-1:0] pri2,
  output logic [PW-1:0] pri3,
  output logic [PW-1:0] pri4,
  output logic [PW-1:0] pri5,
  output logic [PW-1:0] pri6,
  output logic [PW-1:0] pri7,
  output logic [PW-1:0] pri8,
  output logic [PW-1:0] pri9,
  output logic [PW-1:0] pri10,
  output logic [PW-1:0] pri11,
  output logic [PW-1:0] pri12,
  output logic [PW-1:0] pri13,
  output logic [PW-1:0] pri14,
  output logic [PW-1:0] pri15,
  output logic [PW-1:0] pri16,
  output logic [PW-1:0] pri17,
  input  logic [PW-1:0] max_val
);
  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

  state_t          state;
  logic [PW-1:0]   p [N_EL];
  logic [PW-1:0]   pm [N_EL];
  logic [N_EL-1:0] sel_acc;
  logic [4:0]      rem;
  logic [4:0]      win;
  logic            found;
  logic [4:0]      cnt_clamp;

  assign bus.in_ready = (state == IDLE);
  assign cnt_clamp    = (bus.in_count > 5'(N_EL)) ? 5'(N_EL) : bus.in_count;

  always_comb begin
    for (int i = 0; i < N_EL; i++) begin
      pm[i] = sel_acc[i] ? '0 : p[i];
    end
  end

  assign pri0  = pm[0];
  assign pri1  = pm[1];
  assign pri2  = pm[2];
  assign pri3  = pm[3];
  assign pri4  = pm[4];
  assign pri5  = pm[5];
  assign pri6  = pm[6];
  assign pri7  = pm[7];
  assign pri8  = pm[8];
  assign pri9  = pm[9];
  assign pri10 = pm[10];
  assign pri11 = pm[11];
  assign pri12 = pm[12];
  assign pri13 = pm[13];
  assign pri14 = pm[14];
  assign pri15 = pm[15];
  assign pri16 = pm[16];
  assign pri17 = pm[17];

  // The !sel_acc qualifier keeps already-taken elements out even when their masked zero equals max_val.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_EL; i++) begin
      if (!found && !sel_acc[i] && (p[i] == max_val)) begin
        win   = 5'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_EL; i++) begin
        p[i] <= '0;
      end
      sel_acc       <= '0;
      rem           <= '0;
      state         <= IDLE;
      bus.out_sel   <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem     <= cnt_clamp;
            sel_acc <= '0;
            state   <= (cnt_clamp == 5'd0) ? UPDATE : SCAN;
          end
        end
        SCAN: begin
          sel_acc[win] <= 1'b1;
          rem          <= rem - 5'd1;
          if (rem == 5'd1) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          for (int i = 0; i < N_EL; i++) begin
            p[i] <= sel_acc[i] ? '0 : ((p[i] == '1) ? p[i] : p[i] + 1'b1);
          end
          bus.out_sel   <= sel_acc;
          bus.out_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dem_lru_select.sv
// tb/tb_dem_lru_select.sv - self-checking bench for dem_lru_select with a rank-based reference model
module tb_dem_lru_select;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] pri [18];
  logic [6:0] max_val;
  int         mp [18];
  int         total = 0;
  int         bad   = 0;
  logic [17:0] got;

  always #5 clk = ~clk;

  dem_lru_select_if bus ();

  dem_lru_select dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pri0(pri[0]),   .pri1(pri[1]),   .pri2(pri[2]),   .pri3(pri[3]),
    .pri4(pri[4]),   .pri5(pri[5]),   .pri6(pri[6]),   .pri7(pri[7]),
    .pri8(pri[8]),   .pri9(pri[9]),   .pri10(pri[10]), .pri11(pri[11]),
    .pri12(pri[12]), .pri13(pri[13]), .pri14(pri[14]), .pri15(pri[15]),
    .pri16(pri[16]), .pri17(pri[17]),
    .max_val(max_val)
  );

  // Stand-in for the external 18-input max stage.
  always_comb begin
    max_val = '0;
    for (int i = 0; i < 18; i++) begin
      if (pri[i] > max_val) max_val = pri[i];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pri_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < 18; i++) f[i*7 +: 7] = pri[i];
    return f;
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < 18; i++) f[i*7 +: 7] = 7'(mp[i]);
    return f;
  endfunction

  // Element i is chosen when fewer than k elements outrank it (higher priority, or equal and lower index).
  function automatic logic [17:0] model_req(input int k);
    int kk;
    int rank;
    logic [17:0] s;
    kk = (k > 18) ? 18 : k;
    s  = '0;
    for (int i = 0; i < 18; i++) begin
      rank = 0;
      for (int j = 0; j < 18; j++) begin
        if (mp[j] > mp[i] || (mp[j] == mp[i] && j < i)) rank++;
      end
      s[i] = (rank < kk);
    end
    for (int i = 0; i < 18; i++) begin
      mp[i] = s[i] ? 0 : ((mp[i] >= 127) ? 127 : mp[i] + 1);
    end
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) mp[i] = 0;
  endtask

  task automatic do_req(input int k, input string tag, output logic [17:0] sel);
    int w;
    int lat;
    int kk;
    logic [17:0] exp;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".ready"}, 128'(bus.in_ready), 128'(1));
    kk = (k > 18) ? 18 : k;
    bus.in_valid = 1'b1;
    bus.in_count = 5'(k);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    exp = model_req(k);
    chk({tag, ".latency"}, 128'(lat), 128'(kk + 2));
    chk({tag, ".out_sel"}, 128'(bus.out_sel), 128'(exp));
    chk({tag, ".pri"}, pri_flat(), model_flat());
    sel = bus.out_sel;
  endtask

  initial begin
    logic [17:0] q [$];
    logic [17:0] e;
    int nacc;
    int nov;
    int nbad_ov;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    for (int i = 0; i < 18; i++) mp[i] = 0;

    do_reset();
    chk("reset.in_ready", 128'(bus.in_ready), 128'(1));
    chk("reset.out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset.out_sel", 128'(bus.out_sel), 128'(0));
    chk("reset.pri", pri_flat(), 128'(0));

    for (int n = 0; n < 3; n++) begin
      do_req(0, "k0", got);
      chk("k0.zero_sel", 128'(got), 128'(0));
    end
    chk("k0.pri3", 128'(pri[5]), 128'(3));

    do_reset();
    do_req(3, "k3a", got);
    chk("k3a.const", 128'(got), 128'(18'h00007));
    chk("k3a.p3", 128'(pri[3]), 128'(1));
    do_req(3, "k3b", got);
    chk("k3b.const", 128'(got), 128'(18'h00038));

    do_req(25, "k25", got);
    chk("k25.const", 128'(got), 128'(18'h3FFFF));
    chk("k25.pri_zero", pri_flat(), 128'(0));

    for (int n = 0; n < 30; n++) begin
      do_req(int'($urandom_range(0, 31)), "rand", got);
    end

    do_reset();
    for (int n = 0; n < 130; n++) begin
      do_req(17, "sat17", got);
    end

    do_reset();
    for (int n = 0; n < 128; n++) begin
      do_req(0, "sat0", got);
    end
    chk("sat0.hold127", 128'(pri[0]), 128'(127));
    chk("sat0.hold127_17", 128'(pri[17]), 128'(127));

    // Hold in_valid through busy periods: only idle cycles may accept.
    do_reset();
    nacc = 0;
    nov = 0;
    nbad_ov = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_count = 5'd2;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        nov++;
        if (q.size() == 0) nbad_ov++;
        else begin
          e = q.pop_front();
          chk("hold.out_sel", 128'(bus.out_sel), 128'(e));
        end
      end
      if (bus.in_ready) begin
        nacc++;
        q.push_back(model_req(2));
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) begin
        nov++;
        if (q.size() == 0) nbad_ov++;
        else begin
          e = q.pop_front();
          chk("hold.out_sel", 128'(bus.out_sel), 128'(e));
        end
      end
      @(negedge clk);
    end
    chk("hold.accepts", 128'(nacc), 128'(5));
    chk("hold.out_valids", 128'(nov), 128'(5));
    chk("hold.spurious", 128'(nbad_ov), 128'(0));
    chk("hold.pri", pri_flat(), model_flat());

    // Reset during the second SCAN cycle of a k=5 request.
    do_req(4, "prerst", got);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_count = 5'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) mp[i] = 0;
    chk("midrst.out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst.pri", pri_flat(), 128'(0));
    chk("midrst.in_ready", 128'(bus.in_ready), 128'(1));
    nov = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) nov++;
      @(negedge clk);
    end
    chk("midrst.no_out", 128'(nov), 128'(0));
    do_req(3, "postrst", got);
    chk("postrst.const", 128'(got), 128'(18'h00007));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
